// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester arbiter that connects an instruction cache (requester 0) and a
// data cache (requester 1) to one shared memory port. Each memory access is
// called a beat. Holding lockN keeps ownership across beats, so that a cache
// line refill or writeback runs as one burst. The burst is cut off after
// MAX_BURST beats, but only if the other requester is waiting.
// When both requesters ask from idle, the grant alternates round-robin,
// based on the last owner.
//
// Ports
//   clk              single clock, all state changes on the rising edge
//   reset            asynchronous, active-low reset
//   req0/req1        access request from requester 0 / 1
//   lock0/lock1      keep the grant after the current beat (burst)
//   we0/we1          write enable of the requester's beat
//   addr0/addr1      beat address              [ADDR_WIDTH]
//   wdata0/wdata1    beat write data           [DATA_WIDTH]
//   ack0/ack1        beat completed for that requester
//   rdata            read data (copy of mout), valid only with ack0/ack1
//   mreq             shared memory request
//   mwrite_en        shared memory write enable
//   maddr            shared memory address     [ADDR_WIDTH]
//   mdata            shared memory write data  [DATA_WIDTH]
//   mout             memory read data          [DATA_WIDTH]
//   mack             memory beat completion
//   grant            one-hot owner (bit0 = req0, bit1 = req1), 00 when idle
//   beat             beats completed in the current grant, saturates at 255
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mreq,
  output logic                  mwrite_en,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic [DATA_WIDTH-1:0] mdata,
  input  logic [DATA_WIDTH-1:0] mout,
  input  logic                  mack,
  output logic [1:0]            grant,
  output logic [7:0]            beat
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  // The burst limit is widened to 9 bits. This lets beat+1 reach 256
  // without wrapping when the two are compared.
  localparam logic [8:0] BURST_LIMIT = 9'(MAX_BURST);

  state_t     state_q, state_d;
  logic       last_q, last_d;    // last owner; a tie from idle goes to !last
  logic [7:0] beat_q, beat_d;

  // Signals of the current owner, so that the release rules are written once.
  logic own_req, own_lock, other_req, own_ack, burst_full, release_now;
  logic owner_id;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. This way every
  // flop samples the values from before the edge, whatever order the
  // simulator evaluates processes in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      beat_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Owner selection
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first. If any
  // path leaves a signal unassigned, a latch is inferred.
  always_comb begin
    owner_id  = 1'b0;
    own_req   = 1'b0;
    own_lock  = 1'b0;
    other_req = 1'b0;
    unique case (state_q)
      GRANT0: begin
        owner_id  = 1'b0;
        own_req   = req0;
        own_lock  = lock0;
        other_req = req1;
      end
      GRANT1: begin
        owner_id  = 1'b1;
        own_req   = req1;
        own_lock  = lock1;
        other_req = req0;
      end
      default: ;
    endcase
  end

  // A beat only counts while the owner is still requesting. A stray mack in
  // IDLE, or after the owner has dropped its request, is ignored.
  assign own_ack    = (state_q != IDLE) && own_req && mack;
  assign burst_full = ({1'b0, beat_q} + 9'd1) >= BURST_LIMIT;

  // Release when:
  //   - the owner abandons its request, or
  //   - a beat completes without lock, or
  //   - a locked beat reaches the burst limit while the other requester waits.
  // A locked owner with no competition is never cut off.
  assign release_now = (state_q != IDLE) &&
                       (!own_req ||
                        (own_ack && !own_lock) ||
                        (own_ack && own_lock && other_req && burst_full));

  // ---------------------------------------------------------------------------
  // Next state, last owner and beat counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1)      state_d = last_q ? GRANT0 : GRANT1;
        else if (req0)         state_d = GRANT0;
        else if (req1)         state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (release_now) begin
          last_d  = owner_id;
          beat_d  = 8'd0;
          // The other requester is handed the grant directly, with no idle
          // cycle in between.
          if (other_req) state_d = owner_id ? GRANT0 : GRANT1;
          else           state_d = IDLE;
        end else if (own_ack && beat_q != 8'hFF) begin
          beat_d = beat_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory-side and requester-side outputs
  // ---------------------------------------------------------------------------
  // The memory outputs are muxed from the owner's inputs without a register.
  // They change within the same cycle, and the requester must hold them
  // stable until ack.
  always_comb begin
    mreq      = 1'b0;
    mwrite_en = 1'b0;
    maddr     = '0;
    mdata     = '0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    unique case (state_q)
      GRANT0: begin
        mreq      = req0;
        mwrite_en = we0;
        maddr     = addr0;
        mdata     = wdata0;
        ack0      = mack & req0;
      end
      GRANT1: begin
        mreq      = req1;
        mwrite_en = we1;
        maddr     = addr1;
        mdata     = wdata1;
        ack1      = mack & req1;
      end
      default: ;
    endcase
  end

  assign grant = state_q;
  assign beat  = beat_q;
  assign rdata = mout;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter, built with MAX_BURST = 4 so that the forced
// release can be reached in a short sequence. Inputs are driven 1 time unit
// after the rising edge. Outputs are checked 1 unit later, well before the
// next edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, lock0, lock1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata;
  logic          mreq, mwrite_en;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata;
  logic [DW-1:0] mout;
  logic          mack;
  logic [1:0]    grant;
  logic [7:0]    beat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .mreq(mreq), .mwrite_en(mwrite_en), .maddr(maddr), .mdata(mdata),
    .mout(mout), .mack(mack), .grant(grant), .beat(beat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mout = 32'h0; mack = 0;

    // ---- reset state ----
    #12;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_beat", 32'(beat), 32'h0);
    check("rst_mreq", 32'(mreq), 32'h0);
    check("rst_acks", {30'd0, ack1, ack0}, 32'h0);
    reset = 1'b1;

    // ---- round-robin tie with mack every cycle ----
    tick();
    req0 = 1; req1 = 1; mack = 1;
    addr0 = 32'hA0; addr1 = 32'hB1; mout = 32'h1234_5678;
    #1;
    check("rr_idle_grant", 32'(grant), 32'h0);
    check("rr_idle_noack", {30'd0, ack1, ack0}, 32'h0);
    check("rr_idle_nomreq", 32'(mreq), 32'h0);
    tick(); #1;
    check("rr_g0", 32'(grant), 32'h1);
    check("rr_g0_acks", {30'd0, ack1, ack0}, 32'h1);
    check("rr_g0_maddr", maddr, 32'hA0);
    tick(); #1;
    check("rr_g1", 32'(grant), 32'h2);
    check("rr_g1_acks", {30'd0, ack1, ack0}, 32'h2);
    check("rr_g1_rdata", rdata, 32'h1234_5678);
    tick(); #1;
    check("rr_g0_again", 32'(grant), 32'h1);
    req0 = 0; req1 = 0; mack = 0;   // owner abandons, nobody else waiting
    tick(); #1;
    check("rr_idle_end", 32'(grant), 32'h0);

    // ---- single write from requester 1, mack on the 3rd cycle ----
    req1 = 1; we1 = 1; addr1 = 32'h100; wdata1 = 32'hDEAD_BEEF;
    addr0 = 32'h55; we0 = 0;
    tick(); #1;
    check("wr_c1_mreq", 32'(mreq), 32'h1);
    check("wr_c1_maddr", maddr, 32'h100);
    check("wr_c1_mdata", mdata, 32'hDEAD_BEEF);
    check("wr_c1_we", 32'(mwrite_en), 32'h1);
    check("wr_c1_noack", 32'(ack1), 32'h0);
    tick();
    addr0 = 32'h777; we0 = 1;        // non-owner activity must not leak
    #1;
    check("wr_c2_maddr", maddr, 32'h100);
    check("wr_c2_we", 32'(mwrite_en), 32'h1);
    check("wr_c2_noack", 32'(ack1), 32'h0);
    tick();
    mack = 1;
    #1;
    check("wr_c3_ack1", 32'(ack1), 32'h1);
    check("wr_c3_ack0", 32'(ack0), 32'h0);
    tick();
    req1 = 0; we1 = 0; mack = 0; we0 = 0;
    #1;
    check("wr_idle", 32'(grant), 32'h0);
    check("wr_idle_mreq", 32'(mreq), 32'h0);
    check("wr_idle_beat", 32'(beat), 32'h0);

    // ---- 8-beat locked refill, no competitor: never forced off ----
    req0 = 1; lock0 = 1; mack = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      addr0 = 32'h200 + 32'(i * 4);
      #1;
      check($sformatf("refill_grant%0d", i), 32'(grant), 32'h1);
      check($sformatf("refill_ack%0d", i), 32'(ack0), 32'h1);
      check($sformatf("refill_beat%0d", i), 32'(beat), 32'(i));
      tick();
    end
    #1;
    check("refill_held", 32'(grant), 32'h1);
    check("refill_beat8", 32'(beat), 32'd8);
    req0 = 0; lock0 = 0; mack = 0;
    tick(); #1;
    check("refill_idle", 32'(grant), 32'h0);
    check("refill_beat_clr", 32'(beat), 32'h0);

    // ---- MAX_BURST = 4 cut-off with requester 1 waiting ----
    req0 = 1; lock0 = 1; mack = 1;
    tick(); #1;
    check("mb_b0", 32'(beat), 32'h0);
    tick();
    req1 = 1;
    #1;
    check("mb_b1", 32'(beat), 32'h1);
    check("mb_b1_grant", 32'(grant), 32'h1);
    tick(); #1;
    check("mb_b2_grant", 32'(grant), 32'h1);
    tick(); #1;
    check("mb_b3_grant", 32'(grant), 32'h1);
    check("mb_b3_ack0", 32'(ack0), 32'h1);
    check("mb_b3_beat", 32'(beat), 32'h3);
    tick(); #1;
    check("mb_switched", 32'(grant), 32'h2);
    check("mb_beat_clr", 32'(beat), 32'h0);

    // ---- requester 0 abandons its request before mack ----
    lock0 = 0; lock1 = 0;             // requester 1 takes one beat and releases
    tick(); #1;
    check("ab_grant0", 32'(grant), 32'h1);
    req0 = 0;                          // mack still 1: must be ignored
    #1;
    check("ab_noack0", 32'(ack0), 32'h0);
    check("ab_noack1", 32'(ack1), 32'h0);
    mack = 0;
    tick(); #1;
    check("ab_grant1", 32'(grant), 32'h2);
    check("ab_beat", 32'(beat), 32'h0);

    // ---- asynchronous reset mid-GRANT1 (last owner is 0 here) ----
    mack = 1;
    #1;
    check("ar_pre_ack1", 32'(ack1), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check("ar_mreq", 32'(mreq), 32'h0);
    check("ar_ack1", 32'(ack1), 32'h0);
    check("ar_grant", 32'(grant), 32'h0);
    mack = 0;
    tick();
    reset = 1'b1;
    req0 = 1; req1 = 1;
    #1;
    check("ar_idle", 32'(grant), 32'h0);
    tick(); #1;
    check("ar_tie_to_0", 32'(grant), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width of all ports.
REQ-003 SHALL have parameter MAX_BURST, default 8, meaning max consecutive locked beats while the other requester waits; legal range 1..255.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (reset = 0 resets).
REQ-006 SHALL have ports req0, req1  input  1 each  requester 0 (instruction cache) / requester 1 (data cache) access request.
REQ-007 SHALL have ports lock0, lock1  input  1 each  hold grant after current beat (line refill/writeback burst).
REQ-008 SHALL have ports we0, we1  input  1 each  write enable of requester's beat.
REQ-009 SHALL have ports addr0, addr1  input  ADDR_WIDTH each  beat address.
REQ-010 SHALL have ports wdata0, wdata1  input  DATA_WIDTH each  beat write data.
REQ-011 SHALL have ports ack0, ack1  output  1 each  beat completed for that requester.
REQ-012 SHALL have port rdata  output  DATA_WIDTH  read data, equal to mout, valid only with ack0/ack1.
REQ-013 SHALL have ports mreq  output  1, mwrite_en  output  1, maddr  output  ADDR_WIDTH, mdata  output  DATA_WIDTH  shared memory request.
REQ-014 SHALL have ports mout  input  DATA_WIDTH, mack  input  1  memory read data and beat completion (1+ cycles after mreq).
REQ-015 SHALL have port grant  output  2  one-hot current owner (bit0 = req0, bit1 = req1), 00 when idle.
REQ-016 SHALL have port beat  output  8  beats completed in current grant.

Function
REQ-017 SHALL implement states IDLE, GRANT0, GRANT1; grant = 00/01/10 respectively.
REQ-018 In IDLE with exactly one reqN = 1, SHALL enter GRANTN next cycle (1-cycle arbitration latency, no mreq during IDLE).
REQ-019 In IDLE with req0 = req1 = 1, SHALL grant the requester not equal to register last (round-robin).
REQ-020 In GRANTN, SHALL drive mreq = reqN, mwrite_en = weN, maddr = addrN, mdata = wdataN, combinationally.
REQ-021 In GRANTN, SHALL drive ackN = mack & reqN; the other ack SHALL be 0; in IDLE both acks SHALL be 0.
REQ-022 In GRANTN, on each beat (mack & reqN) SHALL increment beat, saturating at 255.
REQ-023 In GRANTN, SHALL release on: beat with lockN = 0; or reqN = 0 (abandoned, no ack given); or beat with lockN = 1, other req = 1 and beat+1 >= MAX_BURST.
REQ-024 On release, SHALL set last = N, clear beat, and enter GRANT of the other requester if its req = 1 that cycle, else IDLE.
REQ-025 In GRANTN with lockN = 1 and the other req = 0, SHALL never force release (unbounded burst).
REQ-026 mack while in IDLE or while the owner's req = 0 SHALL be ignored (no ack, no count).
REQ-027 A non-owner's req/we/addr/wdata changes SHALL not affect memory outputs.
REQ-028 Requesters SHALL hold req and beat fields stable until ack; the arbiter does not latch them.

Reset
REQ-029 reset = 0 SHALL immediately force state IDLE, last = 1, beat = 0, grant = 00, ack0 = ack1 = 0, mreq = 0, mwrite_en = 0, regardless of clk.
REQ-030 Reset asserted mid-burst SHALL abandon the burst with no further ack; first grant after reset release on a tie SHALL go to requester 0.

Verification
REQ-031 Reset release, req0 = req1 = 1, lock = 0, mack = 1 every cycle -> grant 00, 01, 10, 01, ...; alternating ack0/ack1 from cycle 2.
REQ-032 req1 only, we1 = 1, addr1 = 0x100, wdata1 = 0xDEADBEEF, mack after 3 cycles -> mreq = 1, maddr = 0x100, mdata = 0xDEADBEEF, mwrite_en = 1 for 3 cycles, ack1 = 1 on cycle 3, then IDLE.
REQ-033 req0 with lock0 = 1 for 8-beat refill, req1 = 0, mack = 1 each cycle -> 8 acks to req0, beat counts 0..7, no forced release.
REQ-034 MAX_BURST = 4, req0 locked, req1 raised at beat 1 -> req0 released after 4th beat; next cycle grant = 10.
REQ-035 req0 granted, drops req0 before mack, req1 = 1 -> no ack0, grant = 10 next cycle, beat = 0.
REQ-036 reset = 0 asynchronously mid-GRANT1 between clock edges -> mreq, ack1, grant drop to 0 immediately; after release tie goes to requester 0.
